// File: rtl/axi_dma_desc_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_dma_desc_arb_pkg
// Shared helpers for the descriptor arbiter and its per-channel FIFO.
//   clog2_min1 : ceiling log2 that never returns less than 1, so that derived
//                pointer/counter widths stay legal for tiny parameter values.
// The descriptor entry layout depends on the arbiter's width parameters, so
// its struct typedef is declared inside axi_dma_desc_arb, next to those
// parameters.
// -----------------------------------------------------------------------------
package axi_dma_desc_arb_pkg;

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi_dma_desc_fifo.sv
// -----------------------------------------------------------------------------
// axi_dma_desc_fifo
// Single-clock descriptor FIFO with registered full/empty flags.
// The head entry is read combinationally (distributed-RAM style), so the
// arbiter can load its output slot in the same cycle it pops the entry.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_data    write request and entry (ignored while full)
//   i_pop             read request (ignored while empty)
//   o_data            current head entry
//   o_full, o_empty   registered status flags
// -----------------------------------------------------------------------------
module axi_dma_desc_fifo
  import axi_dma_desc_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = clog2_min1(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop)      w_count_next = r_count + (PTR_W+1)'(1);
    else if (w_do_pop && !w_do_push) w_count_next = r_count - (PTR_W+1)'(1);
  end

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (PTR_W+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/axi_dma_desc_arb.sv
// -----------------------------------------------------------------------------
// axi_dma_desc_arb
// Multi-channel descriptor arbiter in front of one DMA engine. Each source
// channel has its own FIFO; descriptors are issued round-robin into a single
// registered output slot with the channel index prepended to the tag, and
// engine completions are routed back to the originating channel. A
// per-channel outstanding counter caps how many descriptors a channel may
// have in flight.
// Optional feature: define AXI_DMA_DESC_ARB_PRIO_EN to add the ch_prio input;
// eligible high-priority channels then always win, with round-robin inside
// the winning class using one shared last-grant pointer.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_desc_addr/len/tag/side/valid   per-channel descriptor input, slice i = ch i
//   s_desc_ready                     per-channel FIFO not full
//   m_desc_addr/len/tag/side/valid   registered descriptor to the engine
//   m_desc_ready                     engine accept
//   s_status_tag/valid               engine completion strobe ({ch, tag})
//   m_status_tag/valid               registered per-channel completion
//   ch_enable                        channel may be arbitrated
//   ch_prio                          (optional) high-priority class
//   ch_busy                          FIFO non-empty or descriptors in flight
// -----------------------------------------------------------------------------
module axi_dma_desc_arb
  import axi_dma_desc_arb_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 8,
  parameter int SIDE_WIDTH      = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CH_BITS         = clog2_min1(CHANNELS),
  parameter int M_TAG_WIDTH     = TAG_WIDTH + CH_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [CHANNELS*LEN_WIDTH-1:0]  s_desc_len,
  input  logic [CHANNELS*TAG_WIDTH-1:0]  s_desc_tag,
  input  logic [CHANNELS*SIDE_WIDTH-1:0] s_desc_side,
  input  logic [CHANNELS-1:0]            s_desc_valid,
  output logic [CHANNELS-1:0]            s_desc_ready,
  output logic [ADDR_WIDTH-1:0]          m_desc_addr,
  output logic [LEN_WIDTH-1:0]           m_desc_len,
  output logic [M_TAG_WIDTH-1:0]         m_desc_tag,
  output logic [SIDE_WIDTH-1:0]          m_desc_side,
  output logic                           m_desc_valid,
  input  logic                           m_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]         s_status_tag,
  input  logic                           s_status_valid,
  output logic [CHANNELS*TAG_WIDTH-1:0]  m_status_tag,
  output logic [CHANNELS-1:0]            m_status_valid,
  input  logic [CHANNELS-1:0]            ch_enable,
`ifdef AXI_DMA_DESC_ARB_PRIO_EN
  input  logic [CHANNELS-1:0]            ch_prio,
`endif
  output logic [CHANNELS-1:0]            ch_busy
);

  localparam int CNT_W = clog2_min1(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [TAG_WIDTH-1:0]  tag;
    logic [SIDE_WIDTH-1:0] side;
  } desc_t;

  desc_t [CHANNELS-1:0]         w_fifo_in;
  desc_t [CHANNELS-1:0]         w_fifo_out;
  logic  [CHANNELS-1:0]         w_fifo_full;
  logic  [CHANNELS-1:0]         w_fifo_empty;
  logic  [CHANNELS-1:0]         w_push;
  logic  [CHANNELS-1:0]         w_pop;
  logic  [CHANNELS-1:0]         w_eligible;
  logic  [CHANNELS-1:0]         w_arb_mask;
  logic  [CHANNELS-1:0]         w_status_hit;
  logic  [CH_BITS-1:0]          w_status_ch;
  logic  [CH_BITS-1:0]          w_winner;
  logic                         w_any_grant;
  logic                         w_load;

  logic  [CNT_W-1:0]            r_outstanding [CHANNELS];
  logic  [CH_BITS-1:0]          r_last_grant;
  logic                         r_m_valid;
  desc_t                        r_slot;
  logic  [CH_BITS-1:0]          r_slot_ch;
  logic  [CHANNELS-1:0]         r_status_valid;
  logic  [CHANNELS*TAG_WIDTH-1:0] r_status_tag;

  // Channel index of a completion; values >= CHANNELS match no channel and
  // are silently dropped.
  assign w_status_ch = s_status_tag[M_TAG_WIDTH-1 -: CH_BITS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_fifo_in[gi] = '{addr: s_desc_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
                             len:  s_desc_len[gi*LEN_WIDTH +: LEN_WIDTH],
                             tag:  s_desc_tag[gi*TAG_WIDTH +: TAG_WIDTH],
                             side: s_desc_side[gi*SIDE_WIDTH +: SIDE_WIDTH]};

    assign s_desc_ready[gi] = ~w_fifo_full[gi];
    assign w_push[gi]       = s_desc_valid[gi] & ~w_fifo_full[gi];
    assign w_pop[gi]        = w_load & (w_winner == CH_BITS'(gi));
    assign w_eligible[gi]   = ~w_fifo_empty[gi] & ch_enable[gi] &
                              (r_outstanding[gi] < CNT_W'(MAX_OUTSTANDING));
    assign w_status_hit[gi] = s_status_valid & (w_status_ch == CH_BITS'(gi));
    assign ch_busy[gi]      = ~w_fifo_empty[gi] | (r_outstanding[gi] != '0);

    axi_dma_desc_fifo #(
      .WIDTH ($bits(desc_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[gi]),
      .i_data  (w_fifo_in[gi]),
      .i_pop   (w_pop[gi]),
      .o_data  (w_fifo_out[gi]),
      .o_full  (w_fifo_full[gi]),
      .o_empty (w_fifo_empty[gi])
    );
  end

`ifdef AXI_DMA_DESC_ARB_PRIO_EN
  // Restrict the search to the high-priority class whenever it has a candidate.
  assign w_arb_mask = ((w_eligible & ch_prio) != '0) ? (w_eligible & ch_prio) : w_eligible;
`else
  assign w_arb_mask = w_eligible;
`endif

  // Round-robin: first candidate found scanning from last_grant+1 upward.
  always_comb begin
    w_winner    = '0;
    w_any_grant = 1'b0;
    for (int off = 1; off <= CHANNELS; off++) begin
      if (!w_any_grant && w_arb_mask[CH_BITS'((int'(r_last_grant) + off) % CHANNELS)]) begin
        w_any_grant = 1'b1;
        w_winner    = CH_BITS'((int'(r_last_grant) + off) % CHANNELS);
      end
    end
  end

  assign w_load = w_any_grant & (~r_m_valid | m_desc_ready);

  // Output slot: only a load changes the data, so a stalled descriptor stays
  // stable even if its channel is disabled afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid    <= 1'b0;
      r_slot       <= '0;
      r_slot_ch    <= '0;
      r_last_grant <= CH_BITS'(CHANNELS - 1);
    end else if (w_load) begin
      r_m_valid    <= 1'b1;
      r_slot       <= w_fifo_out[w_winner];
      r_slot_ch    <= w_winner;
      r_last_grant <= w_winner;
    end else if (m_desc_ready) begin
      r_m_valid    <= 1'b0;
    end
  end

  // Outstanding counters and status demux. A simultaneous issue and
  // completion on one channel cancel out; a completion at zero saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_outstanding[i] <= '0;
      r_status_valid <= '0;
      r_status_tag   <= '0;
    end else begin
      r_status_valid <= w_status_hit;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_status_hit[i]) r_status_tag[i*TAG_WIDTH +: TAG_WIDTH] <= s_status_tag[TAG_WIDTH-1:0];
        if (w_pop[i] && !w_status_hit[i])
          r_outstanding[i] <= r_outstanding[i] + CNT_W'(1);
        else if (!w_pop[i] && w_status_hit[i] && (r_outstanding[i] != '0))
          r_outstanding[i] <= r_outstanding[i] - CNT_W'(1);
      end
    end
  end

  assign m_desc_valid   = r_m_valid;
  assign m_desc_addr    = r_slot.addr;
  assign m_desc_len     = r_slot.len;
  assign m_desc_tag     = {r_slot_ch, r_slot.tag};
  assign m_desc_side    = r_slot.side;
  assign m_status_valid = r_status_valid;
  assign m_status_tag   = r_status_tag;

endmodule

// File: tb/tb_axi_dma_desc_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_dma_desc_arb
// Directed scenarios followed by randomized traffic; every cycle the DUT is
// compared against a queue-based reference model of the arbiter's rules.
// Build with AXI_DMA_DESC_ARB_PRIO_EN to exercise the priority class.
// -----------------------------------------------------------------------------
module tb_axi_dma_desc_arb;

  localparam int C     = 3;
  localparam int AW    = 16;
  localparam int LW    = 20;
  localparam int TW    = 8;
  localparam int SW    = 1;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int CHB   = 2;
  localparam int MTW   = TW + CHB;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [TW-1:0] tag;
    logic [SW-1:0] side;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [C*AW-1:0] s_desc_addr;
  logic [C*LW-1:0] s_desc_len;
  logic [C*TW-1:0] s_desc_tag;
  logic [C*SW-1:0] s_desc_side;
  logic [C-1:0]    s_desc_valid;
  logic [C-1:0]    s_desc_ready;
  logic [AW-1:0]   m_desc_addr;
  logic [LW-1:0]   m_desc_len;
  logic [MTW-1:0]  m_desc_tag;
  logic [SW-1:0]   m_desc_side;
  logic            m_desc_valid;
  logic            m_desc_ready;
  logic [MTW-1:0]  s_status_tag;
  logic            s_status_valid;
  logic [C*TW-1:0] m_status_tag;
  logic [C-1:0]    m_status_valid;
  logic [C-1:0]    ch_enable;
`ifdef AXI_DMA_DESC_ARB_PRIO_EN
  logic [C-1:0]    ch_prio;
`endif
  logic [C-1:0]    ch_busy;

  always #5 clk = ~clk;

  axi_dma_desc_arb #(
    .CHANNELS(C), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .SIDE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_tag(s_desc_tag),
    .s_desc_side(s_desc_side), .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
    .m_desc_side(m_desc_side), .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .s_status_tag(s_status_tag), .s_status_valid(s_status_valid),
    .m_status_tag(m_status_tag), .m_status_valid(m_status_valid),
    .ch_enable(ch_enable),
`ifdef AXI_DMA_DESC_ARB_PRIO_EN
    .ch_prio(ch_prio),
`endif
    .ch_busy(ch_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t           mq [C][$];
  int             m_out [C];
  int             m_last;
  bit             m_sv;
  ent_t           m_slot;
  logic [MTW-1:0] m_tag;
  logic [C-1:0]   m_stv;
  logic [C*TW-1:0] m_stt;
  logic [MTW-1:0] issued [$];

  function automatic logic [C-1:0] prio_mask();
`ifdef AXI_DMA_DESC_ARB_PRIO_EN
    return ch_prio;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      mq[i].delete();
      m_out[i] = 0;
    end
    m_last = C - 1;
    m_sv   = 1'b0;
    m_slot = '0;
    m_tag  = '0;
    m_stv  = '0;
    m_stt  = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [C-1:0] elig, cand, can_push;
    bit   any, load;
    int   win, sch;
    ent_t e;
    if (m_sv && m_desc_ready) begin
      issued.push_back(m_tag);
      $display("[TB] issue ch%0d tag=%h addr=%h len=%h side=%h",
               int'(m_tag) / (1 << TW), m_tag, m_slot.addr, m_slot.len, m_slot.side);
    end
    for (int i = 0; i < C; i++)
      elig[i] = (mq[i].size() > 0) && ch_enable[i] && (m_out[i] < MAXO);
    cand = ((elig & prio_mask()) != '0) ? (elig & prio_mask()) : elig;
    any = 1'b0;
    win = 0;
    for (int k = 1; k <= C; k++) begin
      int c;
      c = (m_last + k) % C;
      if (!any && cand[c]) begin
        any = 1'b1;
        win = c;
      end
    end
    load = any && (!m_sv || m_desc_ready);
    sch = int'(s_status_tag) / (1 << TW);
    m_stv = '0;
    if (s_status_valid && sch < C) begin
      m_stv[sch] = 1'b1;
      m_stt[sch*TW +: TW] = s_status_tag[TW-1:0];
    end
    for (int i = 0; i < C; i++) can_push[i] = s_desc_valid[i] && (mq[i].size() < DEPTH);
    if (load) begin
      e      = mq[win].pop_front();
      m_slot = e;
      m_tag  = {CHB'(win), e.tag};
      m_sv   = 1'b1;
      m_last = win;
    end else if (m_desc_ready) begin
      m_sv = 1'b0;
    end
    for (int i = 0; i < C; i++) begin
      bit inc, dec;
      inc = load && (win == i);
      dec = s_status_valid && (sch == i);
      if (inc && !dec) m_out[i]++;
      else if (dec && !inc && m_out[i] > 0) m_out[i]--;
      if (can_push[i]) begin
        e.addr = s_desc_addr[i*AW +: AW];
        e.len  = s_desc_len[i*LW +: LW];
        e.tag  = s_desc_tag[i*TW +: TW];
        e.side = s_desc_side[i*SW +: SW];
        mq[i].push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    logic [C-1:0] rdy, busy;
    for (int i = 0; i < C; i++) begin
      rdy[i]  = mq[i].size() < DEPTH;
      busy[i] = (mq[i].size() > 0) || (m_out[i] > 0);
    end
    chk("s_desc_ready",   64'(s_desc_ready),   64'(rdy));
    chk("m_desc_valid",   64'(m_desc_valid),   64'(m_sv));
    chk("m_desc_addr",    64'(m_desc_addr),    64'(m_slot.addr));
    chk("m_desc_len",     64'(m_desc_len),     64'(m_slot.len));
    chk("m_desc_tag",     64'(m_desc_tag),     64'(m_tag));
    chk("m_desc_side",    64'(m_desc_side),    64'(m_slot.side));
    chk("m_status_valid", 64'(m_status_valid), 64'(m_stv));
    chk("m_status_tag",   64'(m_status_tag),   64'(m_stt));
    chk("ch_busy",        64'(ch_busy),        64'(busy));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic set_desc(input int ch, input ent_t e);
    s_desc_addr[ch*AW +: AW] = e.addr;
    s_desc_len[ch*LW +: LW]  = e.len;
    s_desc_tag[ch*TW +: TW]  = e.tag;
    s_desc_side[ch*SW +: SW] = e.side;
    s_desc_valid[ch]         = 1'b1;
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.addr = AW'($urandom);
    e.len  = LW'($urandom);
    e.tag  = TW'($urandom);
    e.side = SW'($urandom);
    return e;
  endfunction

  task automatic reset_mid();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("reset_valid", 64'(m_desc_valid), 64'd0);
    chk("reset_busy", 64'(ch_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  ent_t e0;
  logic [C-1:0] all_ones;

  initial begin
    all_ones       = '1;
    s_desc_addr    = '0;
    s_desc_len     = '0;
    s_desc_tag     = '0;
    s_desc_side    = '0;
    s_desc_valid   = '0;
    m_desc_ready   = 1'b0;
    s_status_tag   = '0;
    s_status_valid = 1'b0;
    ch_enable      = all_ones;
`ifdef AXI_DMA_DESC_ARB_PRIO_EN
    ch_prio        = '0;
`endif
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel: push on ch2, visible two edges later as {2,5}.
    e0 = '{addr: 16'h0100, len: 20'd64, tag: 8'd5, side: 1'b0};
    set_desc(2, e0);
    cycle();
    s_desc_valid = '0;
    chk("single_t1_valid", 64'(m_desc_valid), 64'd0);
    cycle();
    chk("single_t2_valid", 64'(m_desc_valid), 64'd1);
    chk("single_tag", 64'(m_desc_tag), 64'h205);
    chk("single_addr", 64'(m_desc_addr), 64'h100);
    m_desc_ready = 1'b1;
    cycle();
    m_desc_ready = 1'b0;
    chk("single_busy_before", 64'(ch_busy[2]), 64'd1);
    s_status_tag   = 10'h205;
    s_status_valid = 1'b1;
    cycle();
    s_status_valid = 1'b0;
    chk("single_status_valid", 64'(m_status_valid), 64'b100);
    chk("single_status_tag", 64'(m_status_tag[2*TW +: TW]), 64'd5);
    chk("single_busy_after", 64'(ch_busy[2]), 64'd0);

    // Round-robin: three descriptors per channel, then drain one per cycle
    // until every channel reaches its outstanding limit.
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < C; ch++) set_desc(ch, rand_ent());
      cycle();
    end
    s_desc_valid = '0;
    m_desc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_valid", 64'(m_desc_valid), 64'd1);
      chk("rr_order", 64'(m_desc_tag[MTW-1 -: CHB]), 64'(i % C));
      cycle();
    end
    chk("limit_hold", 64'(m_desc_valid), 64'd0);

    // One completion for ch1 frees one slot; the third ch1 descriptor is
    // loaded on the following edge, together with another ch1 completion.
    s_status_tag   = {2'd1, 8'h33};
    s_status_valid = 1'b1;
    cycle();
    chk("limit_no_early", 64'(m_desc_valid), 64'd0);
    s_status_tag = {2'd1, 8'h34};
    cycle();
    chk("limit_third_valid", 64'(m_desc_valid), 64'd1);
    chk("limit_third_ch", 64'(m_desc_tag[MTW-1 -: CHB]), 64'd1);
    s_status_tag = {2'd1, 8'h35};
    cycle();
    chk("same_cycle_busy", 64'(ch_busy[1]), 64'd0);

    // Channel index 3 does not exist: dropped.
    s_status_tag = {2'd3, 8'hAA};
    cycle();
    s_status_valid = 1'b0;
    chk("drop_status", 64'(m_status_valid), 64'd0);

    // Load the slot, then reset mid-operation.
    m_desc_ready = 1'b0;
    set_desc(1, rand_ent());
    cycle();
    s_desc_valid = '0;
    cycle();
    chk("pre_reset_valid", 64'(m_desc_valid), 64'd1);
    reset_mid();

    // Backpressure: ch0 only, engine stalled for 10 cycles.
    ch_enable = 3'b001;
    for (int k = 0; k < 10; k++) begin
      e0 = rand_ent();
      e0.addr = AW'(16'hA000 + k);
      set_desc(0, e0);
      cycle();
    end
    s_desc_valid = '0;
    chk("bp_ready0", 64'(s_desc_ready[0]), 64'd0);
    chk("bp_valid", 64'(m_desc_valid), 64'd1);
    chk("bp_addr_stable", 64'(m_desc_addr), 64'hA000);
    ch_enable = all_ones;

    // Randomized traffic, with one reset in the middle. Completions are
    // drawn from issued tags, invalid channels, or arbitrary values.
    for (int n = 0; n < 1500; n++) begin
      int r;
      if (n == 750) reset_mid();
      for (int ch = 0; ch < C; ch++) begin
        if ($urandom_range(0, 1) == 1) set_desc(ch, rand_ent());
        else s_desc_valid[ch] = 1'b0;
        ch_enable[ch] = ($urandom_range(0, 9) != 0);
      end
      m_desc_ready = ($urandom_range(0, 9) < 7);
`ifdef AXI_DMA_DESC_ARB_PRIO_EN
      if ($urandom_range(0, 15) == 0) ch_prio = C'($urandom);
`endif
      s_status_valid = 1'b0;
      r = $urandom_range(0, 9);
      if (r < 4 && issued.size() > 0) begin
        int idx;
        idx = $urandom_range(0, issued.size() - 1);
        s_status_tag = issued[idx];
        issued.delete(idx);
        s_status_valid = 1'b1;
      end else if (r == 4) begin
        s_status_tag   = {2'd3, 8'($urandom)};
        s_status_valid = 1'b1;
      end else if (r == 5) begin
        s_status_tag   = MTW'($urandom);
        s_status_valid = 1'b1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
